// File: rtl/monopix_readout_ctrl_if.sv
// rtl/monopix_readout_ctrl_if.sv - decoded hit word stream from the readout controller
interface monopix_readout_ctrl_if #(
    parameter int DATA_W = 27
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/monopix_readout_ctrl.sv
// rtl/monopix_readout_ctrl.sv - token-driven MONOPIX column readout with FWFT output FIFO
module monopix_readout_ctrl #(
    parameter int DATA_W     = 27,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 8
) (
    input  logic                   clk_bx,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [CNT_W-1:0]       cfg_wait_dly,
    input  logic [CNT_W-1:0]       cfg_read_len,
    input  logic [CNT_W-1:0]       cfg_ser_dly,
    input  logic                   token,
    input  logic                   data_in,
    output logic                   freeze,
    output logic                   read,
    output logic                   busy,
    output logic                   overflow,
    output logic [15:0]            hit_cnt,
    input  logic                   clear_cnt,
    monopix_readout_ctrl_if.master out_if
);
    // SHIFT spans ser_dly + DATA_W cycles, so the counter needs headroom above CNT_W
    localparam int DLY_W = CNT_W + $clog2(DATA_W) + 1;
    localparam int AW    = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        TOKEN_WAIT,
        READ,
        SHIFT,
        STORE
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [DLY_W-1:0]  dly_cnt;
    logic [CNT_W-1:0]  wait_q;
    logic [CNT_W-1:0]  read_q;
    logic [CNT_W-1:0]  ser_q;
    logic [DATA_W-1:0] shift_q;

    logic [DLY_W-1:0]  wait_last;
    logic [DLY_W-1:0]  read_last;
    logic [DLY_W-1:0]  skip_end;
    logic [DLY_W-1:0]  shift_last;
    logic              start;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              valid;
    logic              push;
    logic              pop;
    logic              full;
    logic              accept;
    logic              drop;

    always_comb begin
        start      = enable && token;
        wait_last  = DLY_W'(wait_q);
        read_last  = (read_q == '0) ? '0 : DLY_W'(read_q) - DLY_W'(1);
        skip_end   = DLY_W'(ser_q);
        shift_last = DLY_W'(ser_q) + DLY_W'(DATA_W - 1);
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:       if (start) next_state = TOKEN_WAIT;
            TOKEN_WAIT: if (dly_cnt == wait_last) next_state = READ;
            READ:       if (dly_cnt == read_last) next_state = SHIFT;
            SHIFT:      if (dly_cnt == shift_last) next_state = STORE;
            STORE:      next_state = start ? TOKEN_WAIT : IDLE;
            default:    next_state = IDLE;
        endcase
    end

    // Chip strobes are loaded from next_state so they change in step with state
    always_ff @(posedge clk_bx or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            dly_cnt <= '0;
            wait_q  <= '0;
            read_q  <= '0;
            ser_q   <= '0;
            shift_q <= '0;
            freeze  <= 1'b0;
            read    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= next_state;
            dly_cnt <= (next_state != state) ? '0 : dly_cnt + DLY_W'(1);
            if (next_state == TOKEN_WAIT && state != TOKEN_WAIT) begin
                wait_q <= cfg_wait_dly;
                read_q <= cfg_read_len;
                ser_q  <= cfg_ser_dly;
            end
            if (state == SHIFT && dly_cnt >= skip_end) begin
                shift_q <= {shift_q[DATA_W-2:0], data_in};
            end
            freeze <= (next_state == TOKEN_WAIT) || (next_state == READ) ||
                      (next_state == SHIFT);
            read   <= (next_state == READ);
            busy   <= (next_state != IDLE);
        end
    end

    always_comb begin
        valid  = (count != '0);
        push   = (state == STORE);
        full   = (count == (AW+1)'(FIFO_DEPTH));
        pop    = valid && out_if.out_ready;
        accept = push && (!full || pop);
        drop   = push && full && !pop;
    end

    assign out_if.out_valid = valid;
    assign out_if.out_data  = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk_bx) begin
        if (accept) begin
            mem[wr_ptr] <= shift_q;
        end
    end

    always_ff @(posedge clk_bx or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            hit_cnt  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (accept && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !accept) begin
                count <= count - (AW+1)'(1);
            end
            // A clear coinciding with a push or drop wins
            if (clear_cnt) begin
                overflow <= 1'b0;
                hit_cnt  <= '0;
            end else begin
                if (drop) overflow <= 1'b1;
                if (accept && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_monopix_readout_ctrl.sv
// tb/tb_monopix_readout_ctrl.sv - directed self-checking bench for monopix_readout_ctrl
module tb_monopix_readout_ctrl;
    logic        clk_bx = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  cfg_wait_dly = '0;
    logic [7:0]  cfg_read_len = '0;
    logic [7:0]  cfg_ser_dly = '0;
    logic        token = 1'b0;
    logic        data_in = 1'b0;
    logic        clear_cnt = 1'b0;
    logic        freeze;
    logic        read;
    logic        busy;
    logic        overflow;
    logic [15:0] hit_cnt;

    int checks = 0;
    int errors = 0;
    int vcnt = 0;
    logic [26:0] rx_q[$];

    monopix_readout_ctrl_if #(.DATA_W(27)) out_if ();

    monopix_readout_ctrl #(.DATA_W(27), .FIFO_DEPTH(8), .CNT_W(8)) dut (
        .clk_bx       (clk_bx),
        .rst_n        (rst_n),
        .enable       (enable),
        .cfg_wait_dly (cfg_wait_dly),
        .cfg_read_len (cfg_read_len),
        .cfg_ser_dly  (cfg_ser_dly),
        .token        (token),
        .data_in      (data_in),
        .freeze       (freeze),
        .read         (read),
        .busy         (busy),
        .overflow     (overflow),
        .hit_cnt      (hit_cnt),
        .clear_cnt    (clear_cnt),
        .out_if       (out_if.master)
    );

    always #5 clk_bx = ~clk_bx;

    always @(negedge clk_bx) begin
        #1;
        if (out_if.out_valid === 1'b1) vcnt++;
        if (out_if.out_valid === 1'b1 && out_if.out_ready === 1'b1) rx_q.push_back(out_if.out_data);
    end

    // Entered at a negedge with token already high; the next posedge enters TOKEN_WAIT.
    task automatic drive_frame(input logic [26:0] w, input int wt, input int rd, input int sr,
                               input bit keep_tok, input int drop_en_at, input bit ready_at_store,
                               output int frz_n, output int rd_n, output int bad);
        int rde;
        int len;
        int s0;
        int j;
        logic [26:0] wv;
        rde = (rd == 0) ? 1 : rd;
        len = wt + 1 + rde + sr + 27 + 1;
        s0 = wt + 1 + rde + sr;
        wv = w;
        frz_n = 0;
        rd_n = 0;
        bad = 0;
        cfg_wait_dly = 8'(wt);
        cfg_read_len = 8'(rd);
        cfg_ser_dly = 8'(sr);
        for (int i = 0; i < len; i++) begin
            @(negedge clk_bx);
            if (i == 0 && !keep_tok) token = 1'b0;
            if (i == 1) begin
                cfg_wait_dly = 8'(wt + 3);
                cfg_read_len = 8'(rd + 2);
                cfg_ser_dly = 8'(sr + 4);
            end
            if (i == drop_en_at) enable = 1'b0;
            if (i == len - 1 && ready_at_store) out_if.out_ready = 1'b1;
            j = i - s0;
            data_in = (j >= 0 && j < 27) ? wv[26-j] : i[0];
            if (freeze === 1'b1) frz_n++;
            if (read === 1'b1) rd_n++;
            if (freeze !== (i < len - 1)) bad++;
            if (read !== (i > wt && i <= wt + rde)) bad++;
            if (busy !== 1'b1) bad++;
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk_bx);
        clear_cnt = 1'b1;
        @(negedge clk_bx);
        clear_cnt = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_bx);
        checks++;
        if (freeze !== 1'b0 || read !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: got freeze=%b read=%b busy=%b expected 0 0 0", freeze, read, busy);
        end
        checks++;
        if (overflow !== 1'b0 || hit_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_status: got overflow=%b hit_cnt=%0d expected 0 0", overflow, hit_cnt);
        end
        checks++;
        if (out_if.out_valid !== 1'b0 || out_if.out_data !== 27'd0) begin
            errors++;
            $display("FAIL reset_fifo: got valid=%b data=%0h expected 0 0", out_if.out_valid, out_if.out_data);
        end
        rst_n = 1'b1;
        enable = 1'b1;
    endtask

    task automatic test_single_frame();
        int f, r, b, v0;
        out_if.out_ready = 1'b1;
        rx_q.delete();
        v0 = vcnt;
        token = 1'b1;
        drive_frame(27'h5A5A5A5, 2, 1, 3, 1'b0, -1, 1'b0, f, r, b);
        checks++;
        if (f !== 34) begin errors++; $display("FAIL t1_freeze_len: got %0d expected 34", f); end
        checks++;
        if (r !== 1) begin errors++; $display("FAIL t1_read_len: got %0d expected 1", r); end
        checks++;
        if (b !== 0) begin errors++; $display("FAIL t1_pattern: got %0d bad cycles expected 0", b); end
        @(negedge clk_bx);
        checks++;
        if (out_if.out_valid !== 1'b1 || out_if.out_data !== 27'h5A5A5A5) begin
            errors++;
            $display("FAIL t1_head: got valid=%b data=%0h expected 1 5a5a5a5", out_if.out_valid, out_if.out_data);
        end
        repeat (3) @(negedge clk_bx);
        checks++;
        if (rx_q.size() !== 1 || rx_q[0] !== 27'h5A5A5A5) begin
            errors++;
            $display("FAIL t1_rx: got %0d words expected 1 word 5a5a5a5", rx_q.size());
        end
        checks++;
        if (vcnt - v0 !== 1) begin errors++; $display("FAIL t1_valid_cycles: got %0d expected 1", vcnt - v0); end
        checks++;
        if (hit_cnt !== 16'd1) begin errors++; $display("FAIL t1_hit_cnt: got %0d expected 1", hit_cnt); end
    endtask

    task automatic test_back_to_back();
        int f, r, b, bsum;
        pulse_clear();
        rx_q.delete();
        bsum = 0;
        token = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            drive_frame(27'(k), 1, 2, 1, k < 3, -1, 1'b0, f, r, b);
            bsum += b;
        end
        checks++;
        if (bsum !== 0) begin errors++; $display("FAIL t2_pattern: got %0d bad cycles expected 0", bsum); end
        @(negedge clk_bx);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL t2_busy_end: got %b expected 0", busy); end
        repeat (3) @(negedge clk_bx);
        checks++;
        if (rx_q.size() !== 3 || rx_q[0] !== 27'h1 || rx_q[1] !== 27'h2 || rx_q[2] !== 27'h3) begin
            errors++;
            $display("FAIL t2_order: got %0d words expected 1,2,3", rx_q.size());
        end
        checks++;
        if (hit_cnt !== 16'd3) begin errors++; $display("FAIL t2_hit_cnt: got %0d expected 3", hit_cnt); end
    endtask

    task automatic test_fifo_full();
        int f, r, b, bsum, bad_w;
        pulse_clear();
        out_if.out_ready = 1'b0;
        rx_q.delete();
        bsum = 0;
        token = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive_frame(27'(k), 0, 1, 0, k < 9, -1, 1'b0, f, r, b);
            bsum += b;
        end
        @(negedge clk_bx);
        checks++;
        if (bsum !== 0) begin errors++; $display("FAIL t3_pattern: got %0d bad cycles expected 0", bsum); end
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL t3_overflow: got %b expected 1", overflow); end
        checks++;
        if (hit_cnt !== 16'd8) begin errors++; $display("FAIL t3_hit_cnt: got %0d expected 8", hit_cnt); end
        checks++;
        if (out_if.out_valid !== 1'b1 || out_if.out_data !== 27'h0) begin
            errors++;
            $display("FAIL t3_head: got valid=%b data=%0h expected 1 0", out_if.out_valid, out_if.out_data);
        end
        clear_cnt = 1'b1;
        @(negedge clk_bx);
        clear_cnt = 1'b0;
        checks++;
        if (overflow !== 1'b0 || hit_cnt !== 16'd0) begin
            errors++;
            $display("FAIL t3_clear: got overflow=%b hit_cnt=%0d expected 0 0", overflow, hit_cnt);
        end
        out_if.out_ready = 1'b1;
        repeat (12) @(negedge clk_bx);
        bad_w = 0;
        for (int k = 0; k < rx_q.size(); k++) if (rx_q[k] !== 27'(k)) bad_w++;
        checks++;
        if (rx_q.size() !== 8 || bad_w !== 0) begin
            errors++;
            $display("FAIL t3_drain: got %0d words (%0d wrong) expected 8 words 0..7", rx_q.size(), bad_w);
        end
    endtask

    task automatic test_enable_drop();
        int f, r, b, act;
        pulse_clear();
        rx_q.delete();
        token = 1'b1;
        drive_frame(27'h2AAAAAA, 0, 1, 2, 1'b1, 9, 1'b0, f, r, b);
        checks++;
        if (b !== 0) begin errors++; $display("FAIL t4_pattern: got %0d bad cycles expected 0", b); end
        act = 0;
        repeat (40) begin
            @(negedge clk_bx);
            if (freeze !== 1'b0 || busy !== 1'b0) act++;
        end
        checks++;
        if (act !== 0) begin errors++; $display("FAIL t4_idle: got %0d active cycles expected 0", act); end
        checks++;
        if (rx_q.size() !== 1 || rx_q[0] !== 27'h2AAAAAA || hit_cnt !== 16'd1) begin
            errors++;
            $display("FAIL t4_stored: got %0d words hit_cnt=%0d expected 1 word 2aaaaaa hit_cnt=1", rx_q.size(), hit_cnt);
        end
        token = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_reset_mid_read();
        int f, r, b;
        pulse_clear();
        out_if.out_ready = 1'b0;
        rx_q.delete();
        token = 1'b1;
        drive_frame(27'h123, 0, 1, 0, 1'b0, -1, 1'b0, f, r, b);
        token = 1'b1;
        drive_frame(27'h456, 0, 1, 0, 1'b0, -1, 1'b0, f, r, b);
        @(negedge clk_bx);
        checks++;
        if (hit_cnt !== 16'd2 || out_if.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL t5_queued: got hit_cnt=%0d valid=%b expected 2 1", hit_cnt, out_if.out_valid);
        end
        cfg_wait_dly = 8'd0;
        cfg_read_len = 8'd3;
        cfg_ser_dly = 8'd0;
        token = 1'b1;
        @(negedge clk_bx);
        token = 1'b0;
        @(negedge clk_bx);
        checks++;
        if (read !== 1'b1 || freeze !== 1'b1) begin
            errors++;
            $display("FAIL t5_in_read: got read=%b freeze=%b expected 1 1", read, freeze);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (read !== 1'b0 || freeze !== 1'b0 || out_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL t5_async: got read=%b freeze=%b valid=%b expected 0 0 0", read, freeze, out_if.out_valid);
        end
        @(negedge clk_bx);
        rst_n = 1'b1;
        @(negedge clk_bx);
        checks++;
        if (out_if.out_valid !== 1'b0 || hit_cnt !== 16'd0 || busy !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL t5_after: got valid=%b hit_cnt=%0d busy=%b overflow=%b expected 0 0 0 0",
                     out_if.out_valid, hit_cnt, busy, overflow);
        end
        out_if.out_ready = 1'b1;
        repeat (4) @(negedge clk_bx);
        checks++;
        if (rx_q.size() !== 0) begin errors++; $display("FAIL t5_empty: got %0d words expected 0", rx_q.size()); end
    endtask

    task automatic test_zero_cfg_push_pop();
        int f, r, b, bsum, bad_w;
        pulse_clear();
        out_if.out_ready = 1'b1;
        token = 1'b1;
        drive_frame(27'h3C, 0, 0, 0, 1'b0, -1, 1'b0, f, r, b);
        checks++;
        if (f !== 29 || r !== 1 || b !== 0) begin
            errors++;
            $display("FAIL t6_timing: got freeze=%0d read=%0d bad=%0d expected 29 1 0", f, r, b);
        end
        @(negedge clk_bx);
        checks++;
        if (busy !== 1'b0 || out_if.out_valid !== 1'b1 || out_if.out_data !== 27'h3C) begin
            errors++;
            $display("FAIL t6_frame_end: got busy=%b valid=%b data=%0h expected 0 1 3c",
                     busy, out_if.out_valid, out_if.out_data);
        end
        @(negedge clk_bx);
        out_if.out_ready = 1'b0;
        rx_q.delete();
        bsum = 0;
        token = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive_frame(27'(16 + k), 0, 0, 0, k < 7, -1, 1'b0, f, r, b);
            bsum += b;
        end
        @(negedge clk_bx);
        checks++;
        if (bsum !== 0 || hit_cnt !== 16'd9 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL t6_fill: got bad=%0d hit_cnt=%0d overflow=%b expected 0 9 0", bsum, hit_cnt, overflow);
        end
        token = 1'b1;
        drive_frame(27'h18, 0, 0, 0, 1'b0, -1, 1'b1, f, r, b);
        @(negedge clk_bx);
        out_if.out_ready = 1'b0;
        checks++;
        if (overflow !== 1'b0 || hit_cnt !== 16'd10) begin
            errors++;
            $display("FAIL t6_push_pop: got overflow=%b hit_cnt=%0d expected 0 10", overflow, hit_cnt);
        end
        out_if.out_ready = 1'b1;
        repeat (12) @(negedge clk_bx);
        bad_w = 0;
        for (int k = 0; k < rx_q.size(); k++) if (rx_q[k] !== 27'(16 + k)) bad_w++;
        checks++;
        if (rx_q.size() !== 9 || bad_w !== 0) begin
            errors++;
            $display("FAIL t6_drain: got %0d words (%0d wrong) expected 9 words 10..18", rx_q.size(), bad_w);
        end
    endtask

    initial begin
        out_if.out_ready = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_fifo_full();
        test_enable_drop();
        test_reset_mid_read();
        test_zero_cfg_push_pop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/monopix_readout_ctrl.md
Name: monopix_readout_ctrl

Overview:
Parametrised token-driven readout controller for one MONOPIX flavour output, running on a single clock domain. It detects the column token and drives freeze/read with run-time programmable timing. It then deserialises one DATA_W-bit hit word from the serial data pad and buffers decoded words in a first-word-fall-through FIFO with valid/ready output. Frame accounting, FIFO overflow flagging and an enable gate are included. One instance per flavour (PMOS_NOSF, PMOS, COMP, HV).

Parameters:
DATA_W, 27, serial word length in bits (col/te/le/row packed, MSB first on the wire)
FIFO_DEPTH, 8, output FIFO entries (power of 2, >=2)
CNT_W, 8, width of the timing configuration fields and internal delay counter

Ports:
clk_bx  in  1  sole clock; all logic on posedge
rst_n  in  1  asynchronous active-low reset
enable  in  1  readout enable; sampled in IDLE and STORE
cfg_wait_dly  in  CNT_W  extra TOKEN_WAIT cycles
cfg_read_len  in  CNT_W  READ pulse length in cycles; 0 is treated as 1
cfg_ser_dly  in  CNT_W  cycles skipped in SHIFT before the first data bit
token  in  1  chip token, already synchronous to clk_bx
data_in  in  1  chip serial data
freeze  out  1  chip freeze
read  out  1  chip read
out_data  out  DATA_W  head-of-FIFO word
out_valid  out  1  FIFO not empty
out_ready  in  1  consumer accept
busy  out  1  state != IDLE
overflow  out  1  sticky: a word was dropped because the FIFO was full
hit_cnt  out  16  words pushed into the FIFO, saturating
clear_cnt  in  1  synchronous clear of hit_cnt and overflow

Behaviour:
- Reset (rst_n=0, async): state=IDLE, delay counter=0, FIFO empty. freeze, read, out_valid, busy, overflow are 0. hit_cnt=0, out_data=0.
- States: IDLE, TOKEN_WAIT, READ, SHIFT, STORE. State and delay counter are registered.
- freeze and read are flops loaded from next_state, so they align with state with no decode glitches.
  - freeze=1 in TOKEN_WAIT, READ and SHIFT.
  - read=1 in READ only.
- IDLE: if enable&token, go to TOKEN_WAIT. On this transition cfg_wait_dly, cfg_read_len and cfg_ser_dly are latched. Config changes mid-frame have no effect.
- TOKEN_WAIT lasts latched wait_dly+1 cycles, then READ.
- READ lasts max(read_len,1) cycles, then SHIFT.
- SHIFT:
  - First ser_dly cycles: skip, no sampling.
  - Next DATA_W cycles: sample data_in into a shift register, MSB first. The bit sampled in sampling cycle j is bit DATA_W-1-j.
  - Then STORE.
- STORE: exactly 1 cycle. Push the word into the FIFO. Next state is TOKEN_WAIT (with config re-latched) if enable&token, else IDLE.
- Delay counter clears on every state change and increments otherwise.
- Frame length: (wait+1)+max(read,1)+ser+DATA_W+1 cycles.
- enable low mid-frame: the current frame completes and its word is stored, then the block goes to IDLE.
- FIFO:
  - First-word fall-through. out_data is the head word and is valid whenever out_valid=1.
  - Pop on out_valid&out_ready.
  - Push when full without a simultaneous pop: word dropped, overflow<=1, hit_cnt unchanged.
  - Push when full with a simultaneous pop: push accepted, no overflow.
  - Push while empty: out_valid rises the cycle after STORE.
- hit_cnt increments on every accepted push and saturates at 16'hFFFF.
- clear_cnt: hit_cnt<=0 and overflow<=0. If it coincides with a push or a drop, the clear wins (result is 0).
- rst_n asserted mid-frame: immediate return to reset values and FIFO contents discarded. No partial word is ever emitted.

Test Plan:
1. Single frame:
   - Stimulus: wait=2, read=1, ser=3; token high for 1 cycle; data_in carries 27'h5A5A5A5 MSB first, starting 7 cycles after TOKEN_WAIT entry; out_ready=1.
   - Response: freeze high exactly 34 cycles; read high exactly 1 cycle (cycle 4); out_data=27'h5A5A5A5 with out_valid for 1 cycle; hit_cnt=1.
2. Back-to-back:
   - Stimulus: token held high for 3 frames, distinct words 27'h1, 27'h2, 27'h3.
   - Response: freeze drops only in the STORE cycles; 3 words in order; hit_cnt=3; busy stays 1 until the last STORE.
3. FIFO full:
   - Stimulus: FIFO_DEPTH=8, out_ready=0, 10 frames with words 0..9.
   - Response: words 0..7 retained in order; overflow=1; hit_cnt=8. Then clear_cnt: overflow=0, hit_cnt=0, and the FIFO still drains 0..7.
4. Enable drop:
   - Stimulus: enable dropped during SHIFT with token held high.
   - Response: word stored, block returns to IDLE, no further freeze while enable=0.
5. Reset mid-READ:
   - Stimulus: rst_n pulsed low during READ with 2 words queued.
   - Response: read, freeze, out_valid drop to 0 asynchronously; after release the FIFO is empty and hit_cnt=0.
6. Zero config and simultaneous push/pop:
   - Stimulus: wait=0, read=0, ser=0; then a push while full with out_ready=1.
   - Response: TOKEN_WAIT lasts 1 cycle, READ lasts 1 cycle, frame is 30 cycles; the push is accepted and overflow stays 0.
